// File: rtl/fetch_pc_if.sv
// fetch_pc_if: fetch-stage bus between the hazard/EX/imem side and fetch_pc_unit.
interface fetch_pc_if;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misaligned_d;
  logic [31:0] fetch_count;
  modport master (
    output stall_f, redirect, redirect_target, instr,
    input  pc_out, instr_d, pc_d, pc_plus4_d, valid_d, misaligned_d, fetch_count
  );
  modport slave (
    input  stall_f, redirect, redirect_target, instr,
    output pc_out, instr_d, pc_d, pc_plus4_d, valid_d, misaligned_d, fetch_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: RV32i program counter plus IF/ID register with stall, redirect and flush.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_pc_if.slave  bus
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic        hold;
  // Redirect outranks stall: a taken branch always flushes IF/ID, even when stalled.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    hold       = bus.stall_f & ~bus.redirect;
    pc_d       = bus.redirect ? {bus.redirect_target[31:2], 2'b00} : hold ? pc_q : pc_plus4;
    instr_d    = bus.redirect ? NOP_INSTR : hold ? instr_q : bus.instr;
    ifid_pc_d  = bus.redirect ? 32'd0 : hold ? ifid_pc_q : pc_q;
    ifid_pc4_d = bus.redirect ? 32'd0 : hold ? ifid_pc4_q : pc_plus4;
    valid_d    = bus.redirect ? 1'b0 : hold ? valid_q : 1'b1;
    mis_d      = bus.redirect ? |bus.redirect_target[1:0] : hold & mis_q;
    cnt_d      = (bus.redirect | bus.stall_f) ? cnt_q : cnt_q + 32'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      instr_q    <= NOP_INSTR;
      ifid_pc_q  <= '0;
      ifid_pc4_q <= '0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pc4_q <= ifid_pc4_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.pc_out       = pc_q;
  assign bus.instr_d      = instr_q;
  assign bus.pc_d         = ifid_pc_q;
  assign bus.pc_plus4_d   = ifid_pc4_q;
  assign bus.valid_d      = valid_q;
  assign bus.misaligned_d = mis_q;
  assign bus.fetch_count  = cnt_q;
endmodule
